// File: rtl/fft16_seq_pkg.sv
// Shared definitions for the 16-point DIF FFT sequencer and its butterfly PE:
// state encoding, transform size, bit reversal and PE word packing.
`ifndef FFT16_SEQ_PKG_MACROS
`define FFT16_SEQ_PKG_MACROS
`define FFT16_PE_PACK(re, im) {(re), (im)}
`define FFT16_PE_RE(w, dw) (w[2*(dw)-1:(dw)])
`define FFT16_PE_IM(w, dw) (w[(dw)-1:0])
`endif

package fft16_seq_pkg;

  localparam int NPT   = 16;
  localparam int LOG2N = 4;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_t;

  // DIF leaves the buffer in bit-reversed order; unload reads through this.
  function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

endpackage

// File: rtl/fft16_addr_gen.sv
// Butterfly address generator: stage s and butterfly m map to the operand
// pair (i, i+span) and the twiddle exponent j<<s, with span = 8>>s.
module fft16_addr_gen (
  input  logic [1:0] s_i,
  input  logic [2:0] m_i,
  output logic [3:0] idx_a_o,
  output logic [3:0] idx_b_o,
  output logic [2:0] power_o
);

  logic [3:0] span;

  assign span = 4'b1000 >> s_i;

  // i is m with a zero inserted at the span bit; j is the low bits of m below it.
  always_comb begin
    idx_a_o = 4'd0;
    power_o = 3'd0;
    case (s_i)
      2'd0: begin
        idx_a_o = {1'b0, m_i};
        power_o = m_i;
      end
      2'd1: begin
        idx_a_o = {m_i[2], 1'b0, m_i[1:0]};
        power_o = {m_i[1:0], 1'b0};
      end
      2'd2: begin
        idx_a_o = {m_i[2:1], 1'b0, m_i[0]};
        power_o = {m_i[0], 2'b00};
      end
      default: begin
        idx_a_o = {m_i, 1'b0};
        power_o = 3'd0;
      end
    endcase
  end

  assign idx_b_o = idx_a_o | span;

endmodule

// File: rtl/fft16_seq.sv
// 16-point radix-2 DIF FFT sequencer: loads 16 real samples, drives 32 butterflies
// through an external PE one pair at a time, then streams X[0..15] in natural order.
module fft16_seq
  import fft16_seq_pkg::*;
#(
  parameter int DW         = 16,
  parameter int PE_TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  input  logic [DW-1:0]   in_data_i,
  output logic            in_ready_o,
  output logic [2*DW-1:0] pe_a_o,
  output logic [2*DW-1:0] pe_b_o,
  output logic [2:0]      pe_power_o,
  output logic            pe_ab_valid_o,
  input  logic [2*DW-1:0] pe_fft_a_i,
  input  logic [2*DW-1:0] pe_fft_b_i,
  input  logic            pe_fft_valid_i,
  output logic            out_valid_o,
  output logic [3:0]      out_idx_o,
  output logic [2*DW-1:0] out_data_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam int TW = $clog2(PE_TIMEOUT) + 1;

  state_t                      state_q, state_d;
  logic [3:0]                  cnt_q;
  logic [1:0]                  s_q;
  logic [2:0]                  m_q;
  logic [TW-1:0]               tmo_q;
  logic                        err_q;
  logic                        stale_q;
  logic                        out_valid_q;
  logic [3:0]                  out_idx_q;
  logic [2*DW-1:0]             out_data_q;
  logic [NPT-1:0][2*DW-1:0]    mem_rd;
  logic [3:0]                  idx_a, idx_b;
  logic [2:0]                  power;
  logic                        load_we, accept, timeout, last_pair;

  fft16_addr_gen u_addr_gen (
    .s_i     (s_q),
    .m_i     (m_q),
    .idx_a_o (idx_a),
    .idx_b_o (idx_b),
    .power_o (power)
  );

  assign load_we   = (state_q == ST_LOAD) && in_valid_i;
  // A result held high across several cycles is taken once; stale_q masks the tail.
  assign accept    = (state_q == ST_WAIT) && pe_fft_valid_i && !stale_q;
  assign timeout   = (state_q == ST_WAIT) && !accept && (tmo_q == TW'(PE_TIMEOUT - 1));
  assign last_pair = (s_q == 2'd3) && (m_q == 3'd7);

  for (genvar gi = 0; gi < NPT; gi++) begin : g_mem
    logic [2*DW-1:0] entry_q;
    always_ff @(posedge clk) begin
      if (load_we && (cnt_q == 4'(gi))) begin
        entry_q <= `FFT16_PE_PACK(in_data_i, {DW{1'b0}});
      end else if (accept && (idx_a == 4'(gi))) begin
        entry_q <= pe_fft_a_i;
      end else if (accept && (idx_b == 4'(gi))) begin
        entry_q <= pe_fft_b_i;
      end
    end
    assign mem_rd[gi] = entry_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: begin
        if (in_valid_i && (cnt_q == 4'(NPT - 1))) state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (accept) begin
          state_d = last_pair ? ST_UNLOAD : ST_ISSUE;
        end else if (timeout) begin
          state_d = ST_LOAD;
        end
      end
      ST_UNLOAD: begin
        if (cnt_q == 4'(NPT - 1)) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    in_ready_o    = 1'b0;
    busy_o        = 1'b1;
    pe_ab_valid_o = 1'b0;
    pe_a_o        = '0;
    pe_b_o        = '0;
    pe_power_o    = '0;
    case (state_q)
      ST_LOAD: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
      end
      ST_ISSUE: begin
        pe_ab_valid_o = 1'b1;
        pe_a_o        = mem_rd[idx_a];
        pe_b_o        = mem_rd[idx_b];
        pe_power_o    = power;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      s_q         <= '0;
      m_q         <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      stale_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
    end else begin
      // cnt_q doubles as the load index and the unload bin; both wrap at 16.
      if (load_we || (state_q == ST_UNLOAD)) cnt_q <= cnt_q + 4'd1;

      if (state_q == ST_ISSUE) begin
        tmo_q <= '0;
      end else if ((state_q == ST_WAIT) && !accept) begin
        tmo_q <= tmo_q + TW'(1);
      end

      if (accept) begin
        m_q <= m_q + 3'd1;
        if (m_q == 3'd7) s_q <= s_q + 2'd1;
      end else if (timeout) begin
        m_q <= '0;
        s_q <= '0;
      end

      if (timeout) err_q <= 1'b1;

      if (accept) begin
        stale_q <= 1'b1;
      end else if (!pe_fft_valid_i) begin
        stale_q <= 1'b0;
      end

      out_valid_q <= (state_q == ST_UNLOAD);
      out_idx_q   <= (state_q == ST_UNLOAD) ? cnt_q : 4'd0;
      out_data_q  <= (state_q == ST_UNLOAD) ? mem_rd[bitrev4(cnt_q)] : '0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_idx_o   = out_idx_q;
  assign out_data_o  = out_data_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_fft16_seq.sv
// Directed bench for fft16_seq with a behavioural butterfly PE of programmable
// latency, hold time and enable.
module tb_fft16_seq;

  localparam int DW         = 16;
  localparam int W          = 2 * DW;
  localparam int PE_TIMEOUT = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid_i;
  logic [DW-1:0]   in_data_i;
  logic            in_ready_o;
  logic [W-1:0]    pe_a_o, pe_b_o;
  logic [2:0]      pe_power_o;
  logic            pe_ab_valid_o;
  logic [W-1:0]    pe_fft_a_i = '0;
  logic [W-1:0]    pe_fft_b_i = '0;
  logic            pe_fft_valid_i = 1'b0;
  logic            out_valid_o;
  logic [3:0]      out_idx_o;
  logic [W-1:0]    out_data_o;
  logic            busy_o;
  logic            err_o;

  fft16_seq #(.DW(DW), .PE_TIMEOUT(PE_TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid_i     (in_valid_i),
    .in_data_i      (in_data_i),
    .in_ready_o     (in_ready_o),
    .pe_a_o         (pe_a_o),
    .pe_b_o         (pe_b_o),
    .pe_power_o     (pe_power_o),
    .pe_ab_valid_o  (pe_ab_valid_o),
    .pe_fft_a_i     (pe_fft_a_i),
    .pe_fft_b_i     (pe_fft_b_i),
    .pe_fft_valid_i (pe_fft_valid_i),
    .out_valid_o    (out_valid_o),
    .out_idx_o      (out_idx_o),
    .out_data_o     (out_data_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pk(input int re, input int im);
    return {DW'(re), DW'(im)};
  endfunction

  function automatic logic [3:0] brev(input int k);
    logic [3:0] v;
    v = 4'(k);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  // Twiddles W16^k = cos - j*sin in Q14.
  int cos_t[8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
  int sin_t[8] = '{0, 6270, 11585, 15137, 16384, 15137, 11585, 6270};

  function automatic void bfly(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] p, output logic [W-1:0] sa,
                               output logic [W-1:0] sb);
    logic signed [DW-1:0] t;
    int ar, ai, br, bi, dr, di, pr, pim;
    t = a[W-1:DW]; ar = t;
    t = a[DW-1:0]; ai = t;
    t = b[W-1:DW]; br = t;
    t = b[DW-1:0]; bi = t;
    sa  = {DW'(ar + br), DW'(ai + bi)};
    dr  = ar - br;
    di  = ai - bi;
    pr  = (dr * cos_t[p] + di * sin_t[p] + 8192) >>> 14;
    pim = (di * cos_t[p] - dr * sin_t[p] + 8192) >>> 14;
    sb  = {DW'(pr), DW'(pim)};
  endfunction

  // Behavioural PE: result appears pe_lat cycles after the issue cycle, held pe_hold cycles.
  int pe_lat = 2;
  int pe_hold = 1;
  bit pe_en = 1'b1;
  bit pend = 1'b0;
  int dly = 0;
  int hold_left = 0;
  logic [W-1:0] ra, rb;

  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
      hold_left = 0;
      pe_fft_valid_i = 1'b0;
    end else begin
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) pe_fft_valid_i = 1'b0;
      end
      if (pend) begin
        dly--;
        if (dly == 0) begin
          pe_fft_a_i = ra;
          pe_fft_b_i = rb;
          pe_fft_valid_i = 1'b1;
          hold_left = pe_hold;
          pend = 1'b0;
        end
      end
      if (pe_ab_valid_o && pe_en) begin
        bfly(pe_a_o, pe_b_o, pe_power_o, ra, rb);
        pend = 1'b1;
        dly = pe_lat;
      end
    end
  end

  int samples[16];
  logic [W-1:0] expd[16];
  logic [W-1:0] refm[16];

  task automatic load_frame(input string tag);
    chk({tag, " in_ready"}, W'(in_ready_o), W'(1));
    for (int n = 0; n < 16; n++) begin
      in_valid_i = 1'b1;
      in_data_i  = DW'(samples[n]);
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    in_data_i  = '0;
    chk({tag, " busy"}, W'(busy_o), W'(1));
  endtask

  task automatic run_expect(input string tag);
    int t = 0;
    while (!out_valid_o && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " out_valid start"}, W'(out_valid_o), W'(1));
    if (out_valid_o) begin
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("%s idx%0d", tag, k), W'(out_idx_o), W'(k));
        chk($sformatf("%s X[%0d]", tag, k), out_data_o, expd[k]);
        chk($sformatf("%s valid%0d", tag, k), W'(out_valid_o), W'(1));
        @(negedge clk);
      end
      chk({tag, " out_valid end"}, W'(out_valid_o), W'(0));
      $display("frame %s: 16 bins checked, miscompares so far %0d", tag, miscompares);
    end
  endtask

  task automatic wait_pulse(input string tag);
    int t = 0;
    while (!pe_ab_valid_o && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " issue"}, W'(pe_ab_valid_o), W'(1));
  endtask

  task automatic set_impulse();
    for (int n = 0; n < 16; n++) samples[n] = (n == 0) ? 100 : 0;
    for (int k = 0; k < 16; k++) expd[k] = pk(100, 0);
  endtask

  task automatic set_dc();
    for (int n = 0; n < 16; n++) samples[n] = 10;
    for (int k = 0; k < 16; k++) expd[k] = (k == 0) ? pk(160, 0) : pk(0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst        = 1'b1;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", W'(in_ready_o), W'(1));
    chk("reset busy", W'(busy_o), W'(0));
    chk("reset err", W'(err_o), W'(0));
    chk("reset pe_ab_valid", W'(pe_ab_valid_o), W'(0));
    chk("reset pe_a", pe_a_o, W'(0));
    chk("reset pe_power", W'(pe_power_o), W'(0));
    chk("reset out_valid", W'(out_valid_o), W'(0));
    chk("reset out_idx", W'(out_idx_o), W'(0));
    chk("reset out_data", out_data_o, W'(0));
    $display("reset state checked");

    // 1. impulse
    set_impulse();
    load_frame("impulse");
    run_expect("impulse");

    // 2. DC
    set_dc();
    load_frame("dc");
    run_expect("dc");

    // 3. issue trace with distinct samples x[n]=n+1
    for (int n = 0; n < 16; n++) begin
      samples[n] = n + 1;
      refm[n] = pk(n + 1, 0);
    end
    load_frame("trace");
    for (int s = 0; s < 4; s++) begin
      for (int m = 0; m < 8; m++) begin
        int span, j, i;
        logic [W-1:0] na, nb;
        span = 8 >> s;
        j = m % span;
        i = (m / span) * 2 * span + j;
        wait_pulse($sformatf("trace s%0d m%0d", s, m));
        chk($sformatf("trace s%0d m%0d pe_a", s, m), pe_a_o, refm[i]);
        chk($sformatf("trace s%0d m%0d pe_b", s, m), pe_b_o, refm[i + span]);
        chk($sformatf("trace s%0d m%0d power", s, m), W'(pe_power_o), W'((j << s) & 7));
        $display("issue s=%0d m=%0d pair (%0d,%0d) power %0d", s, m, i, i + span, (j << s) & 7);
        bfly(refm[i], refm[i + span], 3'((j << s) & 7), na, nb);
        refm[i] = na;
        refm[i + span] = nb;
        @(negedge clk);
        chk($sformatf("trace s%0d m%0d pulse width", s, m), W'(pe_ab_valid_o), W'(0));
      end
    end
    for (int k = 0; k < 16; k++) expd[k] = refm[brev(k)];
    run_expect("trace");

    // 4. slow PE holding valid: one write-back per pair
    pe_lat  = 4;
    pe_hold = 3;
    set_dc();
    load_frame("slowpe");
    run_expect("slowpe");
    chk("slowpe err", W'(err_o), W'(0));
    pe_lat  = 2;
    pe_hold = 1;

    // 5. silent PE: timeout
    pe_en = 1'b0;
    set_dc();
    load_frame("timeout");
    wait_pulse("timeout first");
    repeat (PE_TIMEOUT - 1) @(negedge clk);
    chk("timeout err early", W'(err_o), W'(0));
    repeat (2) @(negedge clk);
    chk("timeout err set", W'(err_o), W'(1));
    chk("timeout in_ready", W'(in_ready_o), W'(1));
    chk("timeout busy", W'(busy_o), W'(0));
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      seen = seen | out_valid_o;
      @(negedge clk);
    end
    chk("timeout no output", W'(seen), W'(0));
    chk("timeout err sticky", W'(err_o), W'(1));
    pe_en = 1'b1;

    // 6. reset during stage 2 WAIT, then a clean frame
    set_impulse();
    load_frame("midrst");
    for (int p = 0; p < 17; p++) begin
      wait_pulse($sformatf("midrst pulse %0d", p));
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("midrst in_ready", W'(in_ready_o), W'(1));
    chk("midrst busy", W'(busy_o), W'(0));
    chk("midrst err", W'(err_o), W'(0));
    chk("midrst pe_ab_valid", W'(pe_ab_valid_o), W'(0));
    chk("midrst pe_a", pe_a_o, W'(0));
    chk("midrst out_valid", W'(out_valid_o), W'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst idle", W'(busy_o), W'(0));
    set_impulse();
    load_frame("after_rst");
    run_expect("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
